instr_prefetch_ctrl: RTL and testbench

- Fetch-side controller between the instruction memory port and the instruction aligner/compressed-decode stage.
- Issues word-aligned read requests on a req/gnt/rvalid bus and keeps up to DEPTH words buffered or in flight.
- Presents buffered words to the aligner with a valid/consume handshake.
- Redirects on jump and discards stale in-flight responses. On debug reset it behaves exactly as on system reset.

---
 rtl/instr_prefetch_ctrl.sv | 138 +++++++++++++
 tb/tb_instr_prefetch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_ctrl.sv
// Instruction prefetch controller. It issues word-aligned reads on a
// req/gnt/rvalid bus, keeps up to DEPTH words buffered or in flight, and hands
// buffered words to the aligner through a ready/consume handshake. A jump
// redirects fetching and drops responses that are still in flight.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   jtag_reset_flag_i    debug reset, same effect as rst_ni low
//   halt_i               blocks new requests
//   jump_flag_i/addr_i   one-cycle redirect strobe and byte target
//   mem_req_o/addr_o     read request and word-aligned address
//   mem_gnt_i            request accepted
//   mem_rvalid_i/rdata_i in-order read response
//   instr_ready_o/instr_o head word of the buffer (0 when empty)
//   word_consume_i       aligner takes the head word
module instr_prefetch_ctrl #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          jtag_reset_flag_i,
  input  logic          halt_i,
  input  logic          jump_flag_i,
  input  logic [AW-1:0] jump_addr_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          instr_ready_o,
  output logic [DW-1:0] instr_o,
  input  logic          word_consume_i
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [AW-3:0] fetch_q, fetch_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic reset_c;
  logic credit_ok;
  logic accept;
  logic push;
  logic pop;
  logic unused_jump_lsb;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign reset_c         = !rst_ni || jtag_reset_flag_i;
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // Credit covers both in-flight requests and words already buffered.
  assign credit_ok  = ({1'b0, outst_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH);
  assign mem_req_o  = !reset_c && !halt_i && !jump_flag_i && credit_ok;
  assign mem_addr_o = {fetch_q, 2'b00};
  assign accept     = mem_req_o && mem_gnt_i;

  // A jump cycle neither pushes nor pops; FLUSH drops responses.
  assign push = mem_rvalid_i && !jump_flag_i && (state_q == RUN);
  assign pop  = (count_q != '0) && word_consume_i && !jump_flag_i;

  assign instr_ready_o = (count_q != '0);
  assign instr_o       = instr_ready_o ? mem_q[rd_ptr_q] : '0;

  // Next-state logic for fetch address, credit counters, FSM and FIFO pointers.
  always_comb begin
    state_d   = state_q;
    fetch_d   = fetch_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (jump_flag_i) begin
      // Everything still in flight after this cycle is stale.
      fetch_d   = jump_addr_i[AW-1:2];
      outst_d   = outst_q - CW'(mem_rvalid_i);
      discard_d = outst_q - CW'(mem_rvalid_i);
      state_d   = (outst_q - CW'(mem_rvalid_i) != '0) ? FLUSH : RUN;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (accept) fetch_d = fetch_q + (AW - 2)'(1);
      outst_d = outst_q + CW'(accept) - CW'(mem_rvalid_i);
      if (state_q == FLUSH && mem_rvalid_i) begin
        discard_d = discard_q - CW'(1);
        if (discard_q == CW'(1)) state_d = RUN;
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers with synchronous reset (system or debug).
  always_ff @(posedge clk_i) begin
    if (reset_c) begin
      state_q   <= RUN;
      fetch_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are only visible through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (!reset_c && push) mem_q[wr_ptr_q] <= mem_rdata_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_c)
    !(push && (count_q == CW'(DEPTH)) && !pop));

endmodule

// File: tb/tb_instr_prefetch_ctrl.sv
module tb_instr_prefetch_ctrl;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          jtag_reset_flag_i;
  logic          halt_i;
  logic          jump_flag_i;
  logic [AW-1:0] jump_addr_i;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          instr_ready_o;
  logic [DW-1:0] instr_o;
  logic          word_consume_i;

  always #5 clk_i = ~clk_i;

  instr_prefetch_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .jtag_reset_flag_i(jtag_reset_flag_i),
    .halt_i           (halt_i),
    .jump_flag_i      (jump_flag_i),
    .jump_addr_i      (jump_addr_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_gnt_i        (mem_gnt_i),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .instr_ready_o    (instr_ready_o),
    .instr_o          (instr_o),
    .word_consume_i   (word_consume_i)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  int vectors     = 0;
  int miscompares = 0;

  // Memory model and reference model state.
  rsp_t        mq[$];
  logic [31:0] m_fetch;
  bit          m_stale[$];
  logic [31:0] m_fifo[$];

  // Stimulus knobs.
  int          gnt_pct, cons_pct, halt_pct, jump_pct, rv_pct, lat_max;
  bit          jump_req;
  logic [31:0] jump_tgt;
  bit          rst_drv, jtag_drv;
  int          cyc;

  // Observation logs taken from the DUT.
  logic [31:0] acc_log[$];
  int          first_gnt_cyc, first_rdy_cyc, grant_cnt;
  bit          watch;
  logic [31:0] watch_word;
  logic        last_req, last_rdy;
  logic [31:0] last_addr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step();
    logic pred_req;
    logic rst_c;
    @(negedge clk_i);
    rst_ni            = rst_drv;
    jtag_reset_flag_i = jtag_drv;
    halt_i            = ($urandom_range(99) < halt_pct);
    if (jump_req) begin
      jump_flag_i = 1'b1;
      jump_addr_i = jump_tgt;
      jump_req    = 1'b0;
    end else if ($urandom_range(99) < jump_pct) begin
      jump_flag_i = 1'b1;
      jump_addr_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
    end else begin
      jump_flag_i = 1'b0;
      jump_addr_i = $urandom;
    end
    word_consume_i = ($urandom_range(99) < cons_pct);
    mem_gnt_i      = ($urandom_range(99) < gnt_pct);
    if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mq[0].data;
      void'(mq.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
    #1;
    rst_c    = !rst_drv || jtag_drv;
    pred_req = !rst_c && !halt_i && !jump_flag_i && ((m_stale.size() + m_fifo.size()) < DEPTH);
    check_eq("mem_req", 32'(mem_req_o), 32'(pred_req));
    check_eq("mem_addr", mem_addr_o, m_fetch);
    check_eq("instr_ready", 32'(instr_ready_o), 32'(m_fifo.size() != 0));
    check_eq("instr", instr_o, (m_fifo.size() != 0) ? m_fifo[0] : 32'h0);
    last_req  = mem_req_o;
    last_rdy  = instr_ready_o;
    last_addr = mem_addr_o;
    if (mem_req_o && mem_gnt_i) begin
      acc_log.push_back(mem_addr_o);
      grant_cnt++;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    end
    if (instr_ready_o && first_rdy_cyc < 0) first_rdy_cyc = cyc;
    if (watch && instr_ready_o) begin
      watch_word = instr_o;
      watch      = 1'b0;
    end
    @(posedge clk_i);
    if (rst_c) begin
      m_fetch = 32'h0;
      m_stale.delete();
      m_fifo.delete();
      mq.delete();
    end else if (jump_flag_i) begin
      if (mem_rvalid_i && m_stale.size() > 0) void'(m_stale.pop_front());
      foreach (m_stale[i]) m_stale[i] = 1'b1;
      m_fifo.delete();
      m_fetch = {jump_addr_i[31:2], 2'b00};
    end else begin
      if (word_consume_i && m_fifo.size() > 0) void'(m_fifo.pop_front());
      if (mem_rvalid_i && m_stale.size() > 0) begin
        if (!m_stale.pop_front()) m_fifo.push_back(mem_rdata_i);
      end
      if (pred_req && mem_gnt_i) begin
        m_stale.push_back(1'b0);
        mq.push_back('{data: data_of(m_fetch), due: cyc + 1 + int'($urandom_range(lat_max))});
        m_fetch = m_fetch + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    step();
    rst_drv = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; jtag_reset_flag_i = 1'b0; halt_i = 1'b0; jump_flag_i = 1'b0;
    jump_addr_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    word_consume_i = 1'b0;
    gnt_pct = 100; cons_pct = 100; halt_pct = 0; jump_pct = 0; rv_pct = 100; lat_max = 0;
    jump_req = 1'b0; jump_tgt = '0; rst_drv = 1'b0; jtag_drv = 1'b0; cyc = 0;
    m_fetch = '0; watch = 1'b0; watch_word = '0; grant_cnt = 0;
    repeat (2) @(posedge clk_i);

    // Reset state, then streaming with grants every cycle.
    do_reset();
    first_gnt_cyc = -1; first_rdy_cyc = -1; acc_log.delete();
    repeat (8) step();
    check_eq("seq_addr0", acc_at(0), 32'h0);
    check_eq("seq_addr1", acc_at(1), 32'h4);
    check_eq("ready_latency", 32'(first_rdy_cyc - first_gnt_cyc), 32'd2);

    // Stalled consumer: credit runs out after DEPTH grants.
    do_reset();
    cons_pct = 0; grant_cnt = 0;
    repeat (6) step();
    check_eq("stall_grants", 32'(grant_cnt), 32'd2);
    check_eq("stall_req", 32'(last_req), 32'd0);
    check_eq("stall_ready", 32'(last_rdy), 32'd1);
    cons_pct = 100; step();
    cons_pct = 0; acc_log.delete();
    repeat (3) step();
    check_eq("stall_next_addr", acc_at(0), 32'h8);

    // Jump with two requests in flight.
    do_reset();
    cons_pct = 100; rv_pct = 0;
    repeat (3) step();
    jump_req = 1'b1; jump_tgt = 32'h106; gnt_pct = 0;
    step();
    rv_pct = 100; gnt_pct = 100; watch = 1'b1; watch_word = '0; acc_log.delete();
    repeat (8) step();
    check_eq("jump_addr", acc_at(0), 32'h104);
    check_eq("jump_first_word", watch_word, data_of(32'h104));

    // Jump coinciding with the only outstanding response.
    do_reset();
    rv_pct = 0; step();
    gnt_pct = 0; rv_pct = 100; jump_req = 1'b1; jump_tgt = 32'h40;
    step();
    gnt_pct = 100; watch = 1'b1; watch_word = '0;
    repeat (6) step();
    check_eq("jump_rv_first_word", watch_word, data_of(32'h40));

    // Withheld grant, halt, and address wrap.
    do_reset();
    gnt_pct = 0;
    repeat (4) step();
    check_eq("hold_addr", last_addr, 32'h0);
    gnt_pct = 100; halt_pct = 100;
    repeat (4) step();
    halt_pct = 0;
    jump_req = 1'b1; jump_tgt = 32'hFFFF_FFFE;
    step();
    acc_log.delete();
    repeat (5) step();
    check_eq("wrap_addr0", acc_at(0), 32'hFFFF_FFFC);
    check_eq("wrap_addr1", acc_at(1), 32'h0);

    // Debug reset with two words buffered.
    do_reset();
    cons_pct = 0;
    repeat (6) step();
    jtag_drv = 1'b1; step();
    jtag_drv = 1'b0; step();
    check_eq("jtag_ready", 32'(last_rdy), 32'd0);
    check_eq("jtag_addr", last_addr, 32'h0);

    // Randomized traffic.
    do_reset();
    repeat (15) begin
      gnt_pct  = int'($urandom_range(20, 100));
      cons_pct = int'($urandom_range(10, 100));
      halt_pct = int'($urandom_range(0, 20));
      jump_pct = int'($urandom_range(0, 6));
      rv_pct   = int'($urandom_range(30, 100));
      lat_max  = int'($urandom_range(0, 3));
      repeat (200) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
